// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Definitions shared by the ALU command sequencer and its sub-modules:
//   - opcode constants, in the same encoding as the ula_8bits Sel_Op input
//   - op_valida(): 1 when an opcode is implemented by the ALU
//   - estado_t: sequencer FSM state encoding
// ---------------------------------------------------------------------------
package ula_pkg;

    localparam logic [3:0] OP_SOMA  = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_RESTO = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_NAND  = 4'd8;
    localparam logic [3:0] OP_NOR   = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_NOT   = 4'd11;
    localparam logic [3:0] OP_CMP   = 4'd12;

    // OCIOSO: waiting for a command
    // EMITE : operands driven to the ALU, waiting for the settle time
    // SAIDA : result captured, waiting for downstream to take it
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EMITE  = 2'd1,
        SAIDA  = 2'd2
    } estado_t;

    // Opcodes 5, 13, 14 and 15 are holes in the ALU's opcode map.
    function automatic logic op_valida(input logic [3:0] op);
        logic v;
        v = 1'b0;
        case (op)
            OP_SOMA, OP_SUB, OP_MUL, OP_DIV, OP_RESTO,
            OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_NOT, OP_CMP: v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ula_classificador.sv
// ---------------------------------------------------------------------------
// ula_classificador
// Combinational command checker. Flags a command that the ALU cannot
// execute meaningfully, so the sequencer can force a zero result.
// Ports:
//   op_i          opcode of the incoming command
//   b_i           effective operand B of the incoming command
//   erro_div_o    division or remainder by zero
//   op_invalida_o opcode falls in a hole of the ALU map (5, 13, 14, 15)
// ---------------------------------------------------------------------------
module ula_classificador
    import ula_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [7:0] b_i,
    output logic       erro_div_o,
    output logic       op_invalida_o
);

    assign erro_div_o    = ((op_i == OP_DIV) || (op_i == OP_RESTO)) && (b_i == 8'h00);
    assign op_invalida_o = !op_valida(op_i);

endmodule

// File: rtl/ula_sequenciador.sv
// ---------------------------------------------------------------------------
// ula_sequenciador
// Registered command front-end for the 8-bit combinational ALU (ula_8bits).
// Takes one command over a valid/ready handshake, drives the ALU operands
// from registers, waits LATENCIA edges for the ALU to settle, captures the
// 16-bit result with status flags and offers it downstream over a second
// valid/ready handshake. An internal accumulator can replace operand A.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. Upstream: In_Valid/In_Ready (In_Ready is 1 only while idle).
// Downstream: Out_Valid/Out_Ready (Out_Valid holds, with stable data,
// until Out_Ready is seen).
//
// Parameters:
//   LATENCIA    edges from accept to capture, legal range 1..15
//   ACC_INICIAL accumulator value after reset and after Limpa_Acc
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   In_Valid/In_Ready   command handshake
//   In_Op, In_A, In_B   command opcode and operands
//   In_Usa_Acc          use the accumulator in place of In_A
//   Limpa_Acc           synchronous accumulator clear (any state)
//   ULA_A/B/Sel         registered ALU inputs
//   ULA_Resultado       ALU result
//   Out_Valid/Out_Ready result handshake
//   Out_Resultado       captured (possibly forced-to-zero) result
//   Out_Zero, Out_Estouro, Out_Erro_Div, Out_Op_Invalida  status flags
//   Acc                 current accumulator
//   Estado              current FSM state (debug)
// ---------------------------------------------------------------------------
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int unsigned LATENCIA    = 1,
    parameter logic [7:0]  ACC_INICIAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [3:0]  In_Op,
    input  logic [7:0]  In_A,
    input  logic [7:0]  In_B,
    input  logic        In_Usa_Acc,
    input  logic        Limpa_Acc,
    output logic [7:0]  ULA_A,
    output logic [7:0]  ULA_B,
    output logic [3:0]  ULA_Sel,
    input  logic [15:0] ULA_Resultado,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [15:0] Out_Resultado,
    output logic        Out_Zero,
    output logic        Out_Estouro,
    output logic        Out_Erro_Div,
    output logic        Out_Op_Invalida,
    output logic [7:0]  Acc,
    output estado_t     Estado
);

    // Counter load value: counting down to 0 gives exactly LATENCIA edges
    // between the accept edge and the capture edge.
    localparam logic [3:0] CONT_INI = 4'(LATENCIA - 1);

    estado_t     estado_q, estado_d;
    logic [3:0]  cont_q, cont_d;
    logic [7:0]  ula_a_q, ula_a_d;
    logic [7:0]  ula_b_q, ula_b_d;
    logic [3:0]  ula_sel_q, ula_sel_d;
    logic        erro_div_q, erro_div_d;   // classification latched at accept
    logic        op_inv_q, op_inv_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_res_q, out_res_d;
    logic        out_zero_q, out_zero_d;
    logic        out_est_q, out_est_d;
    logic        out_erro_q, out_erro_d;
    logic        out_inv_q, out_inv_d;
    logic [7:0]  acc_q, acc_d;

    logic        cls_erro_div;
    logic        cls_op_inv;
    logic        descarta;
    logic [15:0] res_final;

    ula_classificador u_classificador (
        .op_i          (In_Op),
        .b_i           (In_B),
        .erro_div_o    (cls_erro_div),
        .op_invalida_o (cls_op_inv)
    );

    // A failed command still takes the full latency but delivers zero and
    // leaves the accumulator untouched.
    assign descarta  = erro_div_q || op_inv_q;
    assign res_final = descarta ? 16'h0000 : ULA_Resultado;

    always_comb begin
        estado_d    = estado_q;
        cont_d      = cont_q;
        ula_a_d     = ula_a_q;
        ula_b_d     = ula_b_q;
        ula_sel_d   = ula_sel_q;
        erro_div_d  = erro_div_q;
        op_inv_d    = op_inv_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_zero_d  = out_zero_q;
        out_est_d   = out_est_q;
        out_erro_d  = out_erro_q;
        out_inv_d   = out_inv_q;
        acc_d       = acc_q;
        In_Ready    = 1'b0;

        case (estado_q)
            OCIOSO: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    // acc_q is the pre-clear value even when Limpa_Acc is
                    // active on this same edge.
                    ula_a_d    = In_Usa_Acc ? acc_q : In_A;
                    ula_b_d    = In_B;
                    ula_sel_d  = In_Op;
                    erro_div_d = cls_erro_div;
                    op_inv_d   = cls_op_inv;
                    cont_d     = CONT_INI;
                    estado_d   = EMITE;
                end
            end
            EMITE: begin
                if (cont_q == 4'd0) begin
                    out_res_d   = res_final;
                    out_zero_d  = (res_final == 16'h0000);
                    out_est_d   = (res_final[15:8] != 8'h00);
                    out_erro_d  = erro_div_q;
                    out_inv_d   = op_inv_q;
                    out_valid_d = 1'b1;
                    if (!descarta) begin
                        acc_d = ULA_Resultado[7:0];
                    end
                    estado_d = SAIDA;
                end else begin
                    cont_d = cont_q - 4'd1;
                end
            end
            SAIDA: begin
                if (Out_Ready) begin
                    out_valid_d = 1'b0;
                    estado_d    = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // Clear has priority over a capture landing on the same edge.
        if (Limpa_Acc) begin
            acc_d = ACC_INICIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= OCIOSO;
            cont_q      <= 4'd0;
            ula_a_q     <= 8'h00;
            ula_b_q     <= 8'h00;
            ula_sel_q   <= 4'b1111;
            erro_div_q  <= 1'b0;
            op_inv_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= 16'h0000;
            out_zero_q  <= 1'b0;
            out_est_q   <= 1'b0;
            out_erro_q  <= 1'b0;
            out_inv_q   <= 1'b0;
            acc_q       <= ACC_INICIAL;
        end else begin
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            ula_sel_q   <= ula_sel_d;
            erro_div_q  <= erro_div_d;
            op_inv_q    <= op_inv_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_zero_q  <= out_zero_d;
            out_est_q   <= out_est_d;
            out_erro_q  <= out_erro_d;
            out_inv_q   <= out_inv_d;
            acc_q       <= acc_d;
        end
    end

    assign ULA_A           = ula_a_q;
    assign ULA_B           = ula_b_q;
    assign ULA_Sel         = ula_sel_q;
    assign Out_Valid       = out_valid_q;
    assign Out_Resultado   = out_res_q;
    assign Out_Zero        = out_zero_q;
    assign Out_Estouro     = out_est_q;
    assign Out_Erro_Div    = out_erro_q;
    assign Out_Op_Invalida = out_inv_q;
    assign Acc             = acc_q;
    assign Estado          = estado_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// ---------------------------------------------------------------------------
// tb_ula_sequenciador
// Two sequencer instances (index 0: LATENCIA=1, index 1: LATENCIA=4), each
// fed by a behavioural model of the ALU. Directed table, random commands
// against a reference model, and hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_ula_sequenciador;
    import ula_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [2];
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [3:0]  in_op       [2];
    logic [7:0]  in_a        [2];
    logic [7:0]  in_b        [2];
    logic        in_usa_acc  [2];
    logic        limpa_acc   [2];
    logic [7:0]  ula_a       [2];
    logic [7:0]  ula_b       [2];
    logic [3:0]  ula_sel     [2];
    logic [15:0] ula_res     [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [15:0] out_res     [2];
    logic        out_zero    [2];
    logic        out_est     [2];
    logic        out_erro    [2];
    logic        out_inv     [2];
    logic [7:0]  acc         [2];
    estado_t     estado      [2];

    // Behavioural stand-in for ula_8bits. Error/invalid cases return
    // non-zero garbage so that the sequencer's forcing to zero is visible.
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
        logic [7:0] r8;
        case (op)
            4'd0:  return 16'(a) + 16'(b);
            4'd1:  begin r8 = a - b; return {8'h00, r8}; end
            4'd2:  return 16'(a) * 16'(b);
            4'd3:  return (b == 8'h00) ? 16'hFFFF : 16'(a / b);
            4'd4:  return (b == 8'h00) ? 16'hFFFF : 16'(a % b);
            4'd6:  return {8'h00, a & b};
            4'd7:  return {8'h00, a | b};
            4'd8:  return {8'h00, ~(a & b)};
            4'd9:  return {8'h00, ~(a | b)};
            4'd10: return {8'h00, a ^ b};
            4'd11: return {8'h00, ~a};
            4'd12: return (a > b) ? 16'h0001 : ((a == b) ? 16'h0000 : 16'h00FF);
            default: return 16'hDEAD;
        endcase
    endfunction

    assign ula_res[0] = alu_ref(ula_a[0], ula_b[0], ula_sel[0]);
    assign ula_res[1] = alu_ref(ula_a[1], ula_b[1], ula_sel[1]);

    ula_sequenciador #(.LATENCIA(1), .ACC_INICIAL(8'h00)) dut0 (
        .clk(clk), .rst(rst[0]),
        .In_Valid(in_valid[0]), .In_Ready(in_ready[0]), .In_Op(in_op[0]),
        .In_A(in_a[0]), .In_B(in_b[0]), .In_Usa_Acc(in_usa_acc[0]),
        .Limpa_Acc(limpa_acc[0]),
        .ULA_A(ula_a[0]), .ULA_B(ula_b[0]), .ULA_Sel(ula_sel[0]),
        .ULA_Resultado(ula_res[0]),
        .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]),
        .Out_Resultado(out_res[0]), .Out_Zero(out_zero[0]),
        .Out_Estouro(out_est[0]), .Out_Erro_Div(out_erro[0]),
        .Out_Op_Invalida(out_inv[0]), .Acc(acc[0]), .Estado(estado[0])
    );

    ula_sequenciador #(.LATENCIA(4), .ACC_INICIAL(8'h00)) dut1 (
        .clk(clk), .rst(rst[1]),
        .In_Valid(in_valid[1]), .In_Ready(in_ready[1]), .In_Op(in_op[1]),
        .In_A(in_a[1]), .In_B(in_b[1]), .In_Usa_Acc(in_usa_acc[1]),
        .Limpa_Acc(limpa_acc[1]),
        .ULA_A(ula_a[1]), .ULA_B(ula_b[1]), .ULA_Sel(ula_sel[1]),
        .ULA_Resultado(ula_res[1]),
        .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]),
        .Out_Resultado(out_res[1]), .Out_Zero(out_zero[1]),
        .Out_Estouro(out_est[1]), .Out_Erro_Div(out_erro[1]),
        .Out_Op_Invalida(out_inv[1]), .Acc(acc[1]), .Estado(estado[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // ---------------- scoreboard ----------------
    // packed record: {acc[7:0], inv, err, est, zero, res[15:0]}
    logic [27:0] exp_q[$];
    logic [7:0]  m_acc [2];
    int checks;
    int failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [27:0] obs_of(input int d);
        return {acc[d], out_inv[d], out_erro[d], out_est[d], out_zero[d], out_res[d]};
    endfunction

    // Reference model: what one command must deliver, from the rules.
    // limpa=1 means Limpa_Acc is high on the accepting edge.
    task automatic model_cmd(input int d, input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic usa, input logic limpa,
                             output logic [7:0] ea);
        logic err, inv;
        logic [15:0] res;
        ea = usa ? m_acc[d] : a;
        if (limpa) m_acc[d] = 8'h00;
        err = ((op == 4'd3) || (op == 4'd4)) && (b == 8'h00);
        inv = (op == 4'd5) || (op >= 4'd13);
        res = (err || inv) ? 16'h0000 : alu_ref(ea, b, op);
        if (!(err || inv)) m_acc[d] = res[7:0];
        exp_q.push_back({m_acc[d], inv, err, (res[15:8] != 8'h00), (res == 16'h0000), res});
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_reset(input int d, input string name);
        chk(name, {in_ready[d], out_valid[d], out_res[d], out_zero[d], out_est[d],
                   out_erro[d], out_inv[d], ula_a[d], ula_b[d], ula_sel[d], acc[d], estado[d]},
                  {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'hF, 8'h00, OCIOSO});
    endtask

    task automatic pulse_limpa(input int d);
        @(negedge clk);
        limpa_acc[d] = 1'b1;
        @(posedge clk); #1;
        limpa_acc[d] = 1'b0;
        chk("limpa_pulse_acc", 64'(acc[d]), 64'h00);
    endtask

    task automatic accept_cmd(input int d, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic usa, input logic limpa,
                              input logic [7:0] ea);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(in_ready[d]), 64'h1);
        in_op[d] = op; in_a[d] = a; in_b[d] = b; in_usa_acc[d] = usa;
        limpa_acc[d] = limpa;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        limpa_acc[d] = 1'b0;
        chk("ula_regs", {ula_a[d], ula_b[d], ula_sel[d]}, {ea, b, op});
        chk("busy_after_accept", {in_ready[d], estado[d]}, {1'b0, EMITE});
    endtask

    task automatic wait_result(input int d, output logic [27:0] obs);
        int lat;
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(lat_of(d)));
        obs = obs_of(d);
    endtask

    task automatic release_out(input int d, input logic [27:0] obs);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk("release", {out_valid[d], in_ready[d], obs_of(d)}, {1'b0, 1'b1, obs});
    endtask

    task automatic run_random(input int d, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic usa, input logic limpa);
        logic [7:0]  ea;
        logic [27:0] obs, expv;
        model_cmd(d, op, a, b, usa, limpa, ea);
        accept_cmd(d, op, a, b, usa, limpa, ea);
        wait_result(d, obs);
        expv = exp_q.pop_front();
        chk("random_result", 64'(obs), 64'(expv));
        release_out(d, obs);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        usa;
        logic [1:0]  limpa;   // 0 none, 1 pulse before, 2 on accepting edge
        logic [15:0] res;
        logic        zero, est, err, inv;
        logic [7:0]  acc;
    } vec_t;

    vec_t tab[13];

    initial begin
        logic [7:0]  ea;
        logic [27:0] obs, obs2, expv;
        bit          rose;
        checks = 0;
        failures = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; in_op[d] = 4'h0; in_a[d] = 8'h00;
            in_b[d] = 8'h00; in_usa_acc[d] = 1'b0; limpa_acc[d] = 1'b0; out_ready[d] = 1'b0;
            m_acc[d] = 8'h00;
        end

        //            op     a      b      usa   limpa  res       z     e     err   inv   acc
        tab[0]  = '{4'd1,  8'h03, 8'h05, 1'b0, 2'd0, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE};
        tab[1]  = '{4'd2,  8'hC8, 8'h03, 1'b0, 2'd0, 16'h0258, 1'b0, 1'b1, 1'b0, 1'b0, 8'h58};
        tab[2]  = '{4'd0,  8'h55, 8'h07, 1'b1, 2'd1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07};
        tab[3]  = '{4'd0,  8'hAA, 8'h09, 1'b1, 2'd0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10};
        tab[4]  = '{4'd3,  8'h64, 8'h00, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10};
        tab[5]  = '{4'd5,  8'h01, 8'h02, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10};
        tab[6]  = '{4'd4,  8'h11, 8'h05, 1'b0, 2'd0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
        tab[7]  = '{4'd10, 8'hF0, 8'h3C, 1'b0, 2'd0, 16'h00CC, 1'b0, 1'b0, 1'b0, 1'b0, 8'hCC};
        tab[8]  = '{4'd0,  8'h00, 8'h01, 1'b1, 2'd2, 16'h00CD, 1'b0, 1'b0, 1'b0, 1'b0, 8'hCD};
        tab[9]  = '{4'd1,  8'h05, 8'h05, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tab[10] = '{4'd15, 8'h00, 8'h03, 1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        tab[11] = '{4'd4,  8'h09, 8'h00, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tab[12] = '{4'd2,  8'hFF, 8'hFF, 1'b0, 2'd0, 16'hFE01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};

        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check_reset(0, "reset_dut0");
        check_reset(1, "reset_dut1");

        // Directed table on the LATENCIA=1 instance.
        foreach (tab[i]) begin
            if (tab[i].limpa == 2'd1) begin
                pulse_limpa(0);
                m_acc[0] = 8'h00;
            end
            model_cmd(0, tab[i].op, tab[i].a, tab[i].b, tab[i].usa, (tab[i].limpa == 2'd2), ea);
            accept_cmd(0, tab[i].op, tab[i].a, tab[i].b, tab[i].usa, (tab[i].limpa == 2'd2), ea);
            wait_result(0, obs);
            void'(exp_q.pop_front());
            chk($sformatf("table_%0d", i), 64'(obs),
                64'({tab[i].acc, tab[i].inv, tab[i].err, tab[i].est, tab[i].zero, tab[i].res}));
            release_out(0, obs);
        end

        // Random commands on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 30; k++) begin
                logic [7:0] rb;
                rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                run_random(d, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), rb,
                           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            end
        end

        // Back-pressure on LATENCIA=4: result held, new command waits.
        model_cmd(1, 4'd2, 8'h10, 8'h20, 1'b0, 1'b0, ea);
        accept_cmd(1, 4'd2, 8'h10, 8'h20, 1'b0, 1'b0, ea);
        wait_result(1, obs);
        expv = exp_q.pop_front();
        chk("bp_first_result", 64'(obs), 64'(expv));
        @(negedge clk);
        in_op[1] = 4'd0; in_a[1] = 8'h21; in_b[1] = 8'h22; in_usa_acc[1] = 1'b0;
        in_valid[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("bp_hold", {out_valid[1], in_ready[1], ula_sel[1], obs_of(1)},
                           {1'b1, 1'b0, 4'd2, obs});
        end
        model_cmd(1, 4'd0, 8'h21, 8'h22, 1'b0, 1'b0, ea);
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        chk("bp_released", {out_valid[1], in_ready[1]}, {1'b0, 1'b1});
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        chk("bp_second_accept", {in_ready[1], ula_a[1], ula_b[1], ula_sel[1]},
                                {1'b0, ea, 8'h22, 4'd0});
        wait_result(1, obs);
        expv = exp_q.pop_front();
        chk("bp_second_result", 64'(obs), 64'(expv));
        release_out(1, obs);

        // Limpa_Acc on the capture edge: clear wins over the capture.
        model_cmd(1, 4'd0, 8'h21, 8'h01, 1'b0, 1'b0, ea);
        expv = exp_q.pop_back();
        expv[27:20] = 8'h00;
        m_acc[1] = 8'h00;
        accept_cmd(1, 4'd0, 8'h21, 8'h01, 1'b0, 1'b0, ea);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("clear_cap_pre", 64'(out_valid[1]), 64'h0);
        limpa_acc[1] = 1'b1;
        @(posedge clk); #1;
        limpa_acc[1] = 1'b0;
        chk("clear_cap_result", {out_valid[1], obs_of(1)}, {1'b1, expv});
        release_out(1, expv);

        // Reset during EMITE discards the command.
        run_random(1, 4'd0, 8'h05, 8'h06, 1'b0, 1'b0);
        model_cmd(1, 4'd2, 8'h07, 8'h08, 1'b0, 1'b0, ea);
        accept_cmd(1, 4'd2, 8'h07, 8'h08, 1'b0, 1'b0, ea);
        void'(exp_q.pop_back());
        m_acc[1] = 8'h00;
        @(posedge clk); #1;
        chk("emite_state", 64'(estado[1]), 64'(EMITE));
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        check_reset(1, "reset_in_emite");
        rose = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid[1]) rose = 1'b1;
        end
        chk("no_valid_after_reset", 64'(rose), 64'h0);
        run_random(1, 4'd7, 8'h0F, 8'hF0, 1'b0, 1'b0);

        obs2 = 28'h0;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        if (obs2 != 28'h0) $display("unused");
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
